// File: rtl/vga_pkg.sv
// Shared VGA constants, colour types, palette and sprite image for the
// 640x480@60 Hz pixel pipeline.
//   - Timing constants: total, active window and sync lengths.
//   - color_t: 12-bit {R,G,B} colour, 4 bits per channel.
//   - sprite_cfg_t: sprite position plus background colour as one record.
//   - PALETTE: 16-entry colour lookup; index 0 is treated as transparent.
//   - sprite_texel(): built-in sprite image, address {row[3:0], col[3:0]}.
package vga_pkg;

    localparam int H_TOTAL        = 800;
    localparam int V_TOTAL        = 525;
    localparam int H_ACTIVE_START = 144;
    localparam int H_ACTIVE_END   = 783;
    localparam int V_ACTIVE_START = 35;
    localparam int V_ACTIVE_END   = 514;
    localparam int H_SYNC_LEN     = 96;
    localparam int V_SYNC_LEN     = 2;

    typedef logic [11:0] color_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        color_t     bg;
    } sprite_cfg_t;

    // Entry 15 is leftmost; entry 0 is never displayed (transparent).
    localparam color_t [15:0] PALETTE = {
        12'h123, 12'hCCC, 12'h444, 12'hF08,
        12'h08F, 12'h8F0, 12'hF80, 12'h888,
        12'hF0F, 12'h0FF, 12'h0F0, 12'hFF0,
        12'h00F, 12'hF00, 12'hFFF, 12'h000
    };

    // Diagonal-stripe sprite image: index = col + 2*row + 5 (mod 16).
    // Texel (0,0) is index 5; index 0 stripes give transparent holes.
    function automatic logic [3:0] sprite_texel(input logic [7:0] addr);
        return addr[3:0] + addr[7:4] + addr[7:4] + 4'd5;
    endfunction

endpackage

// File: rtl/vga_sprite_overlay_if.sv
// Parameter-update channel for vga_sprite_overlay.
//   posValid/posReady : valid/ready handshake
//   posX, posY        : sprite top-left corner in active-area pixels
//   bgColor           : background colour {R,G,B}
// master = producer (CPU side), slave = the overlay.
interface vga_sprite_overlay_if;
    import vga_pkg::*;

    logic       posValid;
    logic       posReady;
    logic [9:0] posX;
    logic [9:0] posY;
    color_t     bgColor;

    modport master (output posValid, output posX, output posY, output bgColor,
                    input  posReady);
    modport slave  (input  posValid, input  posX, input  posY, input  bgColor,
                    output posReady);
endinterface

// File: rtl/sprite_rom.sv
// 256 x 4-bit synchronous-read sprite ROM.
//   clk25MHz : pixel clock
//   resetN   : synchronous active-low reset (clears the read register)
//   addr     : {row[3:0], col[3:0]}
//   data     : palette index, registered (one cycle after addr)
// The image content comes from vga_pkg::sprite_texel so the ROM is
// self-contained and needs no external memory image.
module sprite_rom
    import vga_pkg::*;
(
    input  logic       clk25MHz,
    input  logic       resetN,
    input  logic [7:0] addr,
    output logic [3:0] data
);

    // Registered ROM read.
    always_ff @(posedge clk25MHz) begin
        if (!resetN) begin
            data <= 4'd0;
        end else begin
            data <= sprite_texel(addr);
        end
    end

endmodule

// File: rtl/vga_sprite_overlay.sv
// Pixel-colour stage behind the 640x480 VGA timing generator.
// Draws a background colour plus one 16x16 indexed-colour sprite with a
// fixed 3-cycle latency from counters/syncs to RGB/syncs.
//   clk25MHz, resetN         : pixel clock, synchronous active-low reset
//   hCount, vCount           : raw timing counters
//   hSyncIn, vSyncIn         : raw sync pulses
//   pos_if (slave)           : position / background update handshake
//   hSync, vSync             : syncs delayed to match colour
//   outRed/outGreen/outBlue  : pixel colour
//   frameTick                : pulse when new parameters take effect
// Build option: define VGA_SPRITE_SCALE2X_EN to draw the sprite at 2x scale.
module vga_sprite_overlay
    import vga_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int RESET_X  = 312,
    parameter int RESET_Y  = 232
) (
    input  logic                       clk25MHz,
    input  logic                       resetN,
    input  logic [9:0]                 hCount,
    input  logic [9:0]                 vCount,
    input  logic                       hSyncIn,
    input  logic                       vSyncIn,
    vga_sprite_overlay_if.slave        pos_if,
    output logic                       hSync,
    output logic                       vSync,
    output logic [3:0]                 outRed,
    output logic [3:0]                 outGreen,
    output logic [3:0]                 outBlue,
    output logic                       frameTick
);

`ifdef VGA_SPRITE_SCALE2X_EN
    localparam int FOOT = 2 * SPRITE_W;
`else
    localparam int FOOT = SPRITE_W;
`endif

    sprite_cfg_t pend_cfg_q, pend_cfg_d;
    sprite_cfg_t act_q, act_d;
    logic        pend_q, pend_d;
    logic        tick_q, tick_d;
    logic        xfer_s, frame_start_s;

    logic [9:0]  x_s, y_s, dx_s, dy_s;
    logic        in_active_s, on_screen_s, in_sprite_s;
    logic [7:0]  rom_addr_s;

    logic        s1_act_q, s1_spr_q, s1_hs_q, s1_vs_q;
    color_t      s1_bg_q;
    logic [7:0]  s1_addr_q;
    logic        s2_act_q, s2_spr_q, s2_hs_q, s2_vs_q;
    color_t      s2_bg_q;
    logic [3:0]  rom_idx_s;
    color_t      pix_s;
    color_t      rgb_q;
    logic        hs_q, vs_q;

    assign xfer_s        = pos_if.posValid && !pend_q;
    assign frame_start_s = (hCount == 10'd0) && (vCount == 10'd0);
    assign pos_if.posReady = ~pend_q;

    // Next-state for pending/active parameter registers and frame tick.
    // A copy at frame start and a new transfer are mutually exclusive,
    // because a transfer is only accepted while nothing is pending.
    always_comb begin
        pend_d     = pend_q;
        pend_cfg_d = pend_cfg_q;
        act_d      = act_q;
        tick_d     = 1'b0;
        if (frame_start_s && pend_q) begin
            act_d  = pend_cfg_q;
            pend_d = 1'b0;
            tick_d = 1'b1;
        end else begin
            act_d  = act_q;
        end
        if (xfer_s) begin
            pend_d     = 1'b1;
            pend_cfg_d = '{x: pos_if.posX, y: pos_if.posY, bg: pos_if.bgColor};
        end else begin
            pend_cfg_d = pend_cfg_q;
        end
    end

    // Parameter registers; reset discards any pending update.
    always_ff @(posedge clk25MHz) begin
        if (!resetN) begin
            pend_q     <= 1'b0;
            pend_cfg_q <= '0;
            act_q      <= '{x: 10'(RESET_X), y: 10'(RESET_Y), bg: 12'h000};
            tick_q     <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_cfg_q <= pend_cfg_d;
            act_q      <= act_d;
            tick_q     <= tick_d;
        end
    end

    // Stage-1 geometry. Offsets use wrapping 10-bit subtraction so a pixel
    // left of / above the sprite yields a huge offset and fails the test.
    // Positions outside the visible area hide the sprite outright so that
    // large values cannot wrap back onto the left/top edge.
    always_comb begin
        x_s         = hCount - 10'(H_ACTIVE_START);
        y_s         = vCount - 10'(V_ACTIVE_START);
        in_active_s = (hCount >= 10'(H_ACTIVE_START)) && (hCount <= 10'(H_ACTIVE_END)) &&
                      (vCount >= 10'(V_ACTIVE_START)) && (vCount <= 10'(V_ACTIVE_END));
        dx_s        = x_s - act_q.x;
        dy_s        = y_s - act_q.y;
        on_screen_s = (act_q.x < 10'(H_ACTIVE_END - H_ACTIVE_START + 1)) &&
                      (act_q.y < 10'(V_ACTIVE_END - V_ACTIVE_START + 1));
        in_sprite_s = in_active_s && on_screen_s &&
                      (dx_s < 10'(FOOT)) && (dy_s < 10'(FOOT));
`ifdef VGA_SPRITE_SCALE2X_EN
        rom_addr_s  = {dy_s[4:1], dx_s[4:1]};
`else
        rom_addr_s  = {dy_s[3:0], dx_s[3:0]};
`endif
    end

    // Stage-1 and stage-2 pipeline registers; the background colour travels
    // with the pixel so a frame-start update never splits a pixel.
    always_ff @(posedge clk25MHz) begin
        if (!resetN) begin
            s1_act_q  <= 1'b0;
            s1_spr_q  <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_bg_q   <= 12'h000;
            s1_addr_q <= 8'd0;
            s2_act_q  <= 1'b0;
            s2_spr_q  <= 1'b0;
            s2_hs_q   <= 1'b0;
            s2_vs_q   <= 1'b0;
            s2_bg_q   <= 12'h000;
        end else begin
            s1_act_q  <= in_active_s;
            s1_spr_q  <= in_sprite_s;
            s1_hs_q   <= hSyncIn;
            s1_vs_q   <= vSyncIn;
            s1_bg_q   <= act_q.bg;
            s1_addr_q <= rom_addr_s;
            s2_act_q  <= s1_act_q;
            s2_spr_q  <= s1_spr_q;
            s2_hs_q   <= s1_hs_q;
            s2_vs_q   <= s1_vs_q;
            s2_bg_q   <= s1_bg_q;
        end
    end

    sprite_rom u_rom (
        .clk25MHz (clk25MHz),
        .resetN   (resetN),
        .addr     (s1_addr_q),
        .data     (rom_idx_s)
    );

    // Stage-3 colour select: blank, background/transparent, or palette.
    always_comb begin
        pix_s = 12'h000;
        if (!s2_act_q) begin
            pix_s = 12'h000;
        end else if (s2_spr_q && (rom_idx_s != 4'd0)) begin
            pix_s = PALETTE[rom_idx_s];
        end else begin
            pix_s = s2_bg_q;
        end
    end

    // Stage-3 output registers.
    always_ff @(posedge clk25MHz) begin
        if (!resetN) begin
            rgb_q <= 12'h000;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            rgb_q <= pix_s;
            hs_q  <= s2_hs_q;
            vs_q  <= s2_vs_q;
        end
    end

    assign outRed    = rgb_q[11:8];
    assign outGreen  = rgb_q[7:4];
    assign outBlue   = rgb_q[3:0];
    assign hSync     = hs_q;
    assign vSync     = vs_q;
    assign frameTick = tick_q;

endmodule
